mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the LC-3 datapath's MAR/MDR memory port. Accepts one read or write request at a time, performs it against the off-chip asynchronous 16-bit SRAM or the memory-mapped I/O register, and returns a one-cycle response with read data. It sits between the datapath's memory-enable/MAR/MDR path and the board SRAM pins, switches and hex display.

## Interface
- WAIT_CYCLES, 2, cycles WE_N/OE_N are held active per SRAM access; legal range 1..15
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Req_Valid  in  1  request present (datapath memory enable)
- Req_Write  in  1  1 = write, 0 = read
- Req_Addr  in  16  word address (MAR)
- Req_Data  in  16  write data (MDR)
- Req_Ready  out  1  responder can accept; reset 1
- Rsp_Valid  out  1  one-cycle completion pulse, reads and writes; reset 0
- Rsp_Data  out  16  read data, held until next read completes; reset 0
- SRAM_ADDR  out  20  {4'h0, Req_Addr}; reset 0
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low strobes; reset all 1
- SRAM_DQ  inout  16  driven only during write SETUP/ACCESS/HOLD, else Z; reset Z
- Switches  in  16  asynchronous board switches
- HEX_Data  out  16  memory-mapped display register; reset 0

## Operation
- Request accepted on the rising edge where Req_Valid && Req_Ready. Address, data and direction are latched; Req_Ready drops the following cycle.
- Req_Ready is 1 only in IDLE. Req_Valid while not ready is ignored, not queued.
- I/O address 16'hFFFF bypasses the SRAM and leaves every SRAM strobe inactive. A read returns synchronized Switches. A write loads HEX_Data.
- FSM states:
  - IDLE: accepting. Goes to IO_RSP on an I/O address, otherwise to SETUP.
  - SETUP: CE_N=0, UB_N=LB_N=0, address stable, DQ driven if write. Goes to ACCESS.
  - ACCESS: OE_N=0 (read) or WE_N=0 (write) for WAIT_CYCLES cycles, counted by a down-counter. A read captures SRAM_DQ into Rsp_Data on the last ACCESS edge. Then reads go to RESP, writes to HOLD.
  - HOLD (write only): WE_N=1, CE_N=0, DQ still driven, giving one cycle of data hold. Goes to RESP.
  - IO_RSP / RESP: Rsp_Valid=1, CE_N=1, DQ=Z. Goes to IDLE.
- SRAM_ADDR and write data come from latched registers and stay stable from SETUP through HOLD, independent of later Req_* changes.
- Writes leave Rsp_Data unchanged. I/O reads load Rsp_Data in IO_RSP.
- Switches pass through a 2-flop synchronizer. An I/O read returns the synchronizer output sampled at the acceptance edge.
- Reset_n low at any point, including mid-access:
  - FSM goes to IDLE and all strobes go inactive immediately (asynchronously).
  - DQ goes Z, the counter clears, and Rsp_Data and HEX_Data go to 0.
  - An in-flight access is abandoned with no Rsp_Valid.

## Timing
- Acceptance edge = cycle 0.
- SRAM read: SETUP in cycle 1, ACCESS in cycles 2..1+W, Rsp_Valid in cycle 2+W (W=2: cycle 4), Req_Ready back to 1 in cycle 3+W.
- SRAM write: Rsp_Valid in cycle 3+W (W=2: cycle 5).
- I/O access: Rsp_Valid in cycle 1, Req_Ready back to 1 in cycle 2.
- Back-to-back: with Req_Valid held high, a new request is accepted on the first IDLE edge. There is no dead cycle beyond RESP.
- All outputs are registered, with no combinational path from Req_* to any SRAM pin. The one exception is SRAM_DQ, which is enabled by a registered signal.
- The tristate enable and WE_N never change on the same edge: DQ is enabled in SETUP before WE_N falls and released after HOLD.

## Structure
- Shared package mem_pkg:
  - state enum mem_state_t {IDLE, SETUP, ACCESS, HOLD, IO_RSP, RESP}
  - IO_HEX_SW_ADDR = 16'hFFFF
  - SRAM_ADDR_W = 20
- One sub-module, sync_bus, a parameterized 2-flop synchronizer with asynchronous active-low reset, used for Switches.
- Counter width is $clog2(WAIT_CYCLES+1).

## Test plan
- Reset: hold Reset_n=0 -> Req_Ready=1, Rsp_Valid=0, all SRAM strobes=1, DQ=Z, HEX_Data=0, Rsp_Data=0.
- SRAM write then read, W=2:
  - Write 16'h1234 to 16'h0040 -> WE_N low exactly 2 cycles, Rsp_Valid in cycle 5.
  - Read 16'h0040 with the SRAM model -> Rsp_Data=16'h1234, Rsp_Valid in cycle 4.
- I/O:
  - Write 16'hBEEF to 16'hFFFF -> HEX_Data=16'hBEEF, Rsp_Valid in cycle 1, CE_N stays 1.
  - Switches=16'h00A5, wait 3 cycles, read 16'hFFFF -> Rsp_Data=16'h00A5.
- Back-to-back: Req_Valid held high across 3 reads -> each response spaced 2+W+1 cycles, Req_Ready low throughout each transaction, and Req_Addr changes mid-access do not alter SRAM_ADDR.
- Reset mid-write: drop Reset_n during ACCESS -> WE_N=1 and DQ=Z the same cycle, no Rsp_Valid, and the next request completes normally.
- WAIT_CYCLES=1 and 15 -> OE_N/WE_N low width matches the parameter exactly.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    IO_RSP,
    RESP
  } mem_state_t;

  // Word address of the memory-mapped switch/hex register.
  localparam logic [15:0] IO_HEX_SW_ADDR = 16'hFFFF;

  // Width of the board SRAM address bus.
  localparam int SRAM_ADDR_W = 20;

  // True when a datapath address targets the I/O register instead of SRAM.
  function automatic logic is_io_addr(input logic [15:0] addr);
    return addr == IO_HEX_SW_ADDR;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake between the LC-3 datapath (master) and the
// memory responder (slave).
interface mem_responder_if;

  logic        Req_Valid;
  logic        Req_Write;
  logic [15:0] Req_Addr;
  logic [15:0] Req_Data;
  logic        Req_Ready;
  logic        Rsp_Valid;
  logic [15:0] Rsp_Data;

  modport master (
    output Req_Valid, Req_Write, Req_Addr, Req_Data,
    input  Req_Ready, Rsp_Valid, Rsp_Data
  );

  modport slave (
    input  Req_Valid, Req_Write, Req_Addr, Req_Data,
    output Req_Ready, Rsp_Valid, Rsp_Data
  );

endinterface

// File: rtl/sync_bus.sv
// Two-flop synchronizer for a bus of slowly changing asynchronous inputs
// (board switches). Bits are synchronized independently; the consumer only
// samples a settled value.
module sync_bus #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage shift of the asynchronous input into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make both stages sample the old values,
      // so the chain really is two flops deep rather than collapsing into one.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the LC-3 MAR/MDR port. Runs one request at a time
// against the asynchronous 16-bit board SRAM or the memory-mapped switch/hex
// register, and returns a one-cycle response pulse. Every pin is driven from
// a register so no Req_* input reaches the SRAM combinationally.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2  // cycles OE_N/WE_N stay low per SRAM access, 1..15
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  mem_responder_if.slave         bus,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  inout  wire  [15:0]            SRAM_DQ,
  input  logic [15:0]            Switches,
  output logic [15:0]            HEX_Data
);

  localparam int              CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic [15:0]      wdata_q;
  logic             dq_oe;
  logic             ready_q;
  logic             rsp_valid_q;
  logic [15:0]      rsp_data_q;
  logic [15:0]      sw_sync;

  sync_bus #(.WIDTH(16)) u_sw_sync (
    .clk   (Clk),
    .rst_n (Reset_n),
    .d     (Switches),
    .q     (sw_sync)
  );

  assign bus.Req_Ready = ready_q;
  assign bus.Rsp_Valid = rsp_valid_q;
  assign bus.Rsp_Data  = rsp_data_q;

  // NOTE: the tristate enable is a flop set one state ahead of WE_N falling and
  // cleared one state after WE_N rises, so the bus never turns around on the
  // same edge as the write strobe.
  assign SRAM_DQ = dq_oe ? wdata_q : 'z;

  // Request sequencer: latches the request, walks the SRAM strobe sequence
  // or the I/O shortcut, and issues the response pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      dq_oe       <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      HEX_Data    <= '0;
      SRAM_ADDR   <= '0;
      SRAM_CE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
      SRAM_UB_N   <= 1'b1;
      SRAM_LB_N   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Req_Valid) begin
            ready_q   <= 1'b0;
            wr_q      <= bus.Req_Write;
            wdata_q   <= bus.Req_Data;
            SRAM_ADDR <= {{(SRAM_ADDR_W-16){1'b0}}, bus.Req_Addr};
            if (is_io_addr(bus.Req_Addr)) begin
              // I/O completes immediately; SRAM strobes stay idle.
              state       <= IO_RSP;
              rsp_valid_q <= 1'b1;
              if (bus.Req_Write) HEX_Data   <= bus.Req_Data;
              else               rsp_data_q <= sw_sync;
            end else begin
              state     <= SETUP;
              SRAM_CE_N <= 1'b0;
              SRAM_UB_N <= 1'b0;
              SRAM_LB_N <= 1'b0;
              dq_oe     <= bus.Req_Write;
            end
          end
        end

        SETUP: begin
          state <= ACCESS;
          cnt   <= CNT_LOAD;
          if (wr_q) SRAM_WE_N <= 1'b0;
          else      SRAM_OE_N <= 1'b0;
        end

        ACCESS: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            if (wr_q) begin
              state <= HOLD;
            end else begin
              // OE_N is still low on this edge, so the SRAM is driving DQ.
              rsp_data_q  <= SRAM_DQ;
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              SRAM_CE_N   <= 1'b1;
              SRAM_UB_N   <= 1'b1;
              SRAM_LB_N   <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_LAST;
          end
        end

        HOLD: begin
          state       <= RESP;
          rsp_valid_q <= 1'b1;
          dq_oe       <= 1'b0;
          SRAM_CE_N   <= 1'b1;
          SRAM_UB_N   <= 1'b1;
          SRAM_LB_N   <= 1'b1;
        end

        IO_RSP, RESP: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          dq_oe       <= 1'b0;
          SRAM_CE_N   <= 1'b1;
          SRAM_OE_N   <= 1'b1;
          SRAM_WE_N   <= 1'b1;
          SRAM_UB_N   <= 1'b1;
          SRAM_LB_N   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a behavioural SRAM on the pins, a memory/register
// model of what each request should return, directed cases and a random run
// on a WAIT_CYCLES=2 instance, plus strobe-width checks on W=1 and W=15 copies.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int W = 2;
  localparam int P = 3 + W;  // back-to-back read period

  typedef struct {
    int          lat;
    int          we_w;
    int          oe_w;
    int          ce_w;
    logic        ready_low;
    logic        addr_ok;
    logic        ready_back;
    logic        rsp_after;
    logic [15:0] dq_seen;
    logic [15:0] dq_rsp;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT, W=2 ----------------
  mem_responder_if bus ();
  logic [19:0] sram_addr;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  tri1  [15:0] sram_dq;
  logic [15:0] switches = 16'h0;
  logic [15:0] hex;

  mem_responder #(.WAIT_CYCLES(W)) dut (
    .Clk(clk), .Reset_n(rst_n), .bus(bus),
    .SRAM_ADDR(sram_addr), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_DQ(sram_dq), .Switches(switches), .HEX_Data(hex)
  );

  // Behavioural asynchronous SRAM: drives on read, latches on WE_N rising.
  logic [15:0] sram [0:255];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram[sram_addr[7:0]] : 16'bz;
  always @(posedge we_n) if (!ce_n) sram[sram_addr[7:0]] = sram_dq;

  // ---------------- width-check DUTs, W=1 and W=15 ----------------
  logic        aux_valid = 1'b0, aux_write = 1'b0;
  logic [15:0] aux_addr = 16'h0, aux_data = 16'h0;

  mem_responder_if bus1 ();
  mem_responder_if bus15 ();
  assign bus1.Req_Valid  = aux_valid;  assign bus15.Req_Valid = aux_valid;
  assign bus1.Req_Write  = aux_write;  assign bus15.Req_Write = aux_write;
  assign bus1.Req_Addr   = aux_addr;   assign bus15.Req_Addr  = aux_addr;
  assign bus1.Req_Data   = aux_data;   assign bus15.Req_Data  = aux_data;

  logic [19:0] a1_addr, a15_addr;
  logic        a1_ce, a1_oe, a1_we, a1_ub, a1_lb;
  logic        a15_ce, a15_oe, a15_we, a15_ub, a15_lb;
  tri1  [15:0] a1_dq, a15_dq;
  logic [15:0] a1_hex, a15_hex;
  assign a1_dq  = (!a1_ce && !a1_oe)   ? 16'h5A5A : 16'bz;
  assign a15_dq = (!a15_ce && !a15_oe) ? 16'h5A5A : 16'bz;

  mem_responder #(.WAIT_CYCLES(1)) dut_w1 (
    .Clk(clk), .Reset_n(rst_n), .bus(bus1),
    .SRAM_ADDR(a1_addr), .SRAM_CE_N(a1_ce), .SRAM_OE_N(a1_oe),
    .SRAM_WE_N(a1_we), .SRAM_UB_N(a1_ub), .SRAM_LB_N(a1_lb),
    .SRAM_DQ(a1_dq), .Switches(16'h0), .HEX_Data(a1_hex)
  );

  mem_responder #(.WAIT_CYCLES(15)) dut_w15 (
    .Clk(clk), .Reset_n(rst_n), .bus(bus15),
    .SRAM_ADDR(a15_addr), .SRAM_CE_N(a15_ce), .SRAM_OE_N(a15_oe),
    .SRAM_WE_N(a15_we), .SRAM_UB_N(a15_ub), .SRAM_LB_N(a15_lb),
    .SRAM_DQ(a15_dq), .Switches(16'h0), .HEX_Data(a15_hex)
  );

  // Length of the most recent low pulse on each aux strobe, in cycles.
  int a1_we_run = 0, a1_we_last = 0, a1_oe_run = 0, a1_oe_last = 0;
  int a15_we_run = 0, a15_we_last = 0, a15_oe_run = 0, a15_oe_last = 0;
  always @(negedge clk) begin
    if (!a1_we) a1_we_run++;
    else begin if (a1_we_run != 0) a1_we_last = a1_we_run; a1_we_run = 0; end
    if (!a1_oe) a1_oe_run++;
    else begin if (a1_oe_run != 0) a1_oe_last = a1_oe_run; a1_oe_run = 0; end
    if (!a15_we) a15_we_run++;
    else begin if (a15_we_run != 0) a15_we_last = a15_we_run; a15_we_run = 0; end
    if (!a15_oe) a15_oe_run++;
    else begin if (a15_oe_run != 0) a15_oe_last = a15_oe_run; a15_oe_run = 0; end
  end

  // ---------------- reference model and checking ----------------
  logic [15:0] exp_mem [0:255];
  logic [15:0] exp_hex = 16'h0;
  logic [15:0] exp_rsp = 16'h0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one request from IDLE and observe it cycle by cycle (cycle 1 is the
  // cycle after the acceptance edge). Req_* is scrambled once the request is
  // accepted to show the responder works from its own latched copy.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                        output res_t r);
    @(negedge clk);
    bus.Req_Valid = 1'b1;
    bus.Req_Write = wr;
    bus.Req_Addr  = addr;
    bus.Req_Data  = data;
    @(posedge clk);
    r.lat = -1; r.we_w = 0; r.oe_w = 0; r.ce_w = 0;
    r.ready_low = 1'b1; r.addr_ok = 1'b1;
    r.dq_seen = 16'h0; r.dq_rsp = 16'h0;
    for (int c = 1; c <= 40 && r.lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.Req_Valid = 1'b0;
        bus.Req_Addr  = 16'($urandom);
        bus.Req_Data  = 16'($urandom);
      end
      if (!we_n) begin r.we_w++; r.dq_seen = sram_dq; end
      if (!oe_n) r.oe_w++;
      if (!ce_n) begin
        r.ce_w++;
        if (sram_addr !== {4'h0, addr}) r.addr_ok = 1'b0;
      end
      if (bus.Req_Ready) r.ready_low = 1'b0;
      if (bus.Rsp_Valid) begin r.lat = c; r.dq_rsp = sram_dq; end
    end
    @(negedge clk);
    r.ready_back = bus.Req_Ready;
    r.rsp_after  = bus.Rsp_Valid;
  endtask

  // Run one request and compare everything observable against the model.
  task automatic run_op(input string tag, input logic wr, input logic [15:0] addr,
                        input logic [15:0] data);
    res_t        r;
    logic        io;
    logic [15:0] sw_now;
    int          exp_lat, exp_we, exp_oe, exp_ce;
    io     = (addr == IO_HEX_SW_ADDR);
    sw_now = switches;
    exp_lat = io ? 1 : (wr ? 3 + W : 2 + W);
    exp_we  = (!io && wr)  ? W : 0;
    exp_oe  = (!io && !wr) ? W : 0;
    exp_ce  = io ? 0 : (wr ? W + 2 : W + 1);
    do_req(wr, addr, data, r);
    if (wr) begin
      if (io) exp_hex = data;
      else    exp_mem[addr[7:0]] = data;
    end else begin
      exp_rsp = io ? sw_now : exp_mem[addr[7:0]];
    end
    check({tag, ".lat"},        32'(r.lat),        32'(exp_lat));
    check({tag, ".we_width"},   32'(r.we_w),       32'(exp_we));
    check({tag, ".oe_width"},   32'(r.oe_w),       32'(exp_oe));
    check({tag, ".ce_width"},   32'(r.ce_w),       32'(exp_ce));
    check({tag, ".ready_low"},  32'(r.ready_low),  32'd1);
    check({tag, ".addr_hold"},  32'(r.addr_ok),    32'd1);
    check({tag, ".ready_back"}, 32'(r.ready_back), 32'd1);
    check({tag, ".one_pulse"},  32'(r.rsp_after),  32'd0);
    check({tag, ".dq_rsp_z"},   32'(r.dq_rsp),     32'h0000_FFFF);
    check({tag, ".rsp_data"},   32'(bus.Rsp_Data), 32'(exp_rsp));
    check({tag, ".hex"},        32'(hex),          32'(exp_hex));
    if (!io && wr) check({tag, ".dq_write"}, 32'(r.dq_seen), 32'(data));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] b2b_addr [0:3];
    int          rsp_cyc [$];
    logic [15:0] rsp_dat [$];
    int          bad_ready, bad_addr, k, pulses;

    bus.Req_Valid = 1'b0;
    bus.Req_Write = 1'b0;
    bus.Req_Addr  = 16'h0;
    bus.Req_Data  = 16'h0;
    for (int i = 0; i < 256; i++) begin
      sram[i]    = {8'(i) ^ 8'hC3, 8'(i)};
      exp_mem[i] = {8'(i) ^ 8'hC3, 8'(i)};
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.ready",    32'(bus.Req_Ready), 32'd1);
    check("rst.rsp_v",    32'(bus.Rsp_Valid), 32'd0);
    check("rst.strobes",  32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1F);
    check("rst.dq_z",     32'(sram_dq),       32'h0000_FFFF);
    check("rst.hex",      32'(hex),           32'd0);
    check("rst.rsp_data", 32'(bus.Rsp_Data),  32'd0);
    check("rst.addr",     32'(sram_addr),     32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed SRAM and I/O cases
    run_op("wr_0040", 1'b1, 16'h0040, 16'h1234);
    run_op("rd_0040", 1'b0, 16'h0040, 16'h0000);
    run_op("io_wr",   1'b1, 16'hFFFF, 16'hBEEF);
    switches = 16'h00A5;
    repeat (3) @(negedge clk);
    run_op("io_rd",   1'b0, 16'hFFFF, 16'h0000);

    // Random mix of SRAM and I/O accesses
    for (int n = 0; n < 30; n++) begin
      logic        wr;
      logic [15:0] addr;
      if ($urandom_range(2) == 0) switches = 16'($urandom);
      repeat (3) @(negedge clk);
      wr   = 1'($urandom);
      addr = ($urandom_range(3) == 0) ? IO_HEX_SW_ADDR : 16'h0010 + 16'($urandom_range(15));
      run_op($sformatf("rand%0d", n), wr, addr, 16'($urandom));
    end

    // Back-to-back reads with Req_Valid held high; Req_Addr moves mid-access
    b2b_addr[0] = 16'h0021; b2b_addr[1] = 16'h0022;
    b2b_addr[2] = 16'h0023; b2b_addr[3] = 16'h0024;
    bad_ready = 0; bad_addr = 0;
    @(negedge clk);
    bus.Req_Valid = 1'b1;
    bus.Req_Write = 1'b0;
    bus.Req_Addr  = b2b_addr[0];
    @(posedge clk);
    for (int c = 1; c <= 3 * P + 3; c++) begin
      @(negedge clk);
      k = (c - 1) / P;
      if (bus.Req_Ready !== ((c % P == 0) || c >= 3 * P)) bad_ready++;
      if (k < 3 && !ce_n && sram_addr !== {4'h0, b2b_addr[k]}) bad_addr++;
      if (bus.Rsp_Valid) begin rsp_cyc.push_back(c); rsp_dat.push_back(bus.Rsp_Data); end
      if (c % P == 2 && k < 3) bus.Req_Addr = b2b_addr[k + 1];
      if (c == 2 * P + 1) bus.Req_Valid = 1'b0;
    end
    check("b2b.count",     32'(rsp_cyc.size()), 32'd3);
    check("b2b.ready",     32'(bad_ready),      32'd0);
    check("b2b.addr_hold", 32'(bad_addr),       32'd0);
    for (int i = 0; i < 3 && i < rsp_cyc.size(); i++) begin
      check($sformatf("b2b.rsp_cycle%0d", i), 32'(rsp_cyc[i]), 32'(i * P + 2 + W));
      check($sformatf("b2b.rsp_data%0d", i),  32'(rsp_dat[i]), 32'(exp_mem[b2b_addr[i][7:0]]));
    end
    if (rsp_dat.size() == 3) exp_rsp = rsp_dat[2];

    // Reset dropped during a write ACCESS
    @(negedge clk);
    bus.Req_Valid = 1'b1;
    bus.Req_Write = 1'b1;
    bus.Req_Addr  = 16'h0077;
    bus.Req_Data  = 16'h3C3C;
    @(posedge clk);
    @(negedge clk);
    bus.Req_Valid = 1'b0;
    @(negedge clk);
    check("mid.we_low", 32'(we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid.strobes",  32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1F);
    check("mid.dq_z",     32'(sram_dq),       32'h0000_FFFF);
    check("mid.ready",    32'(bus.Req_Ready), 32'd1);
    check("mid.hex",      32'(hex),           32'd0);
    check("mid.rsp_data", 32'(bus.Rsp_Data),  32'd0);
    exp_hex = 16'h0;
    exp_rsp = 16'h0;
    pulses = 0;
    repeat (2) @(negedge clk) if (bus.Rsp_Valid) pulses++;
    rst_n = 1'b1;
    repeat (8) @(negedge clk) if (bus.Rsp_Valid) pulses++;
    check("mid.no_rsp", 32'(pulses), 32'd0);
    run_op("post_rst_rd", 1'b0, 16'h0040, 16'h0000);
    run_op("post_rst_wr", 1'b1, 16'h0041, 16'h7E57);
    run_op("post_rst_rb", 1'b0, 16'h0041, 16'h0000);

    // Strobe widths at the WAIT_CYCLES extremes
    @(negedge clk);
    aux_valid = 1'b1; aux_write = 1'b1; aux_addr = 16'h0005; aux_data = 16'h1111;
    @(negedge clk);
    aux_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("w1.we_width",  32'(a1_we_last),  32'd1);
    check("w15.we_width", 32'(a15_we_last), 32'd15);
    aux_valid = 1'b1; aux_write = 1'b0;
    @(negedge clk);
    aux_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("w1.oe_width",  32'(a1_oe_last),      32'd1);
    check("w15.oe_width", 32'(a15_oe_last),     32'd15);
    check("w1.rd_data",   32'(bus1.Rsp_Data),   32'h5A5A);
    check("w15.rd_data",  32'(bus15.Rsp_Data),  32'h5A5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
